// File: rtl/rate_meter_pkg.sv
// Shared definitions for the rate measurement blocks.
// Holds the FSM state encoding and the default counter width / timeout,
// which rate_divider also uses so that generator and meter agree.
package rate_meter_pkg;

  localparam int          DEFAULT_WIDTH       = 28;
  localparam int unsigned DEFAULT_TIMEOUT     = 150_000_000;
  localparam int          DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    STALLED = 2'd2
  } state_t;

endpackage

// File: rtl/rate_meter_edge_sync.sv
// edge_sync: synchronises an asynchronous strobe and flags its rising edges.
// Ports:
//   clk    in  1  system clock
//   resetn in  1  synchronous reset, active-low
//   d      in  1  asynchronous input
//   rise   out 1  one-cycle pulse on each synchronised rising edge
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  // primed[SYNC_STAGES] is set once both sync output and prev hold real samples,
  // so a level that is already high at reset release never looks like an edge.
  logic [SYNC_STAGES:0]   primed;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync   <= '0;
      prev   <= 1'b0;
      primed <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], d};
      prev   <= sync[SYNC_STAGES-1];
      primed <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev & primed[SYNC_STAGES];

endmodule

// File: rtl/rate_meter.sv
// rate_meter: measures the period, in clk cycles, of a slow pulse train.
// Ports:
//   clk      in  1      system clock
//   resetn   in  1      synchronous reset, active-low
//   pulse_in in  1      asynchronous pulse train
//   period   out WIDTH  last measured period
//   valid    out 1      period holds an unconsumed result
//   ready    in  1      consumer accepts period when valid & ready
//   stall    out 1      no edge for TIMEOUT cycles (level)
//   overrun  out 1      one-cycle pulse: unconsumed result overwritten
//
// state   | meaning
// IDLE    | waiting for the first edge, nothing to measure against
// ARMED   | counting cycles since the last edge
// STALLED | TIMEOUT reached, counter held until the next edge
module rate_meter
  import rate_meter_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter logic [WIDTH-1:0] TIMEOUT     = WIDTH'(DEFAULT_TIMEOUT)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  input  logic             ready,
  output logic             stall,
  output logic             overrun
);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic             rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pulse_in),
    .rise   (rise)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      stall   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (rise) begin
            state <= ARMED;
            cnt   <= WIDTH'(1);
          end
        end
        ARMED: begin
          if (rise) begin
            cnt <= WIDTH'(1);
          end else if (cnt == TIMEOUT - WIDTH'(1)) begin
            // Reaching TIMEOUT this cycle: stall shows together with the
            // counter hitting TIMEOUT, and the counter then stays there.
            cnt   <= TIMEOUT;
            state <= STALLED;
            stall <= 1'b1;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        STALLED: begin
          if (rise) begin
            state <= ARMED;
            cnt   <= WIDTH'(1);
            stall <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (state == ARMED && rise) begin
        period  <= cnt;
        valid   <= 1'b1;
        overrun <= valid & ~ready;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rate_meter.sv
module tb_rate_meter;
  import rate_meter_pkg::*;

  localparam int WIDTH = 12;

  logic             clk;
  logic             resetn;
  logic             pulse_in;
  logic [WIDTH-1:0] period;
  logic             valid;
  logic             ready;
  logic             stall;
  logic             overrun;

  int tests = 0;
  int fails = 0;
  int ovr_cnt = 0;

  rate_meter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2),
    .TIMEOUT     (12'd1000)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .pulse_in (pulse_in),
    .period   (period),
    .valid    (valid),
    .ready    (ready),
    .stall    (stall),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives a 1-cycle pulse at the current negedge and occupies exactly per cycles.
  // The result (if any) is visible 3 negedges after the drive; one cycle later
  // valid is checked against exp_v4.
  task automatic pulse_chk(input int per, input bit exp_v, input int exp_p,
                           input bit exp_v4, input string tag);
    pulse_in = 1'b1;
    @(negedge clk);
    pulse_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(valid), 32'(exp_v));
    if (exp_v) chk({tag, "_period"}, 32'(period), exp_p);
    @(negedge clk);
    chk({tag, "_valid_next"}, 32'(valid), 32'(exp_v4));
    repeat (per - 4) @(negedge clk);
  endtask

  initial begin
    logic bad;
    int   o0;

    // reset with pulse_in already high
    resetn   = 1'b0;
    pulse_in = 1'b1;
    ready    = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    chk("rst_period",  32'(period),  0);
    chk("rst_valid",   32'(valid),   0);
    chk("rst_stall",   32'(stall),   0);
    chk("rst_overrun", 32'(overrun), 0);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (valid !== 1'b0 || stall !== 1'b0 || overrun !== 1'b0 ||
          period !== '0 || dut.u_sync.rise !== 1'b0) bad = 1'b1;
    end
    chk("high_at_release_quiet", 32'(bad), 0);
    pulse_in = 1'b0;
    repeat (10) @(negedge clk);

    // pulses every 100, ready high
    o0 = ovr_cnt;
    pulse_chk(100, 1'b0, 0, 1'b0, "p100_first");
    repeat (4) pulse_chk(100, 1'b1, 100, 1'b0, "p100");
    chk("p100_no_overrun", ovr_cnt - o0, 0);

    // pulses every 50, ready low for three results
    pulse_chk(50, 1'b1, 100, 1'b0, "p50_lead");
    ready = 1'b0;
    o0 = ovr_cnt;
    pulse_chk(50, 1'b1, 50, 1'b1, "p50_a");
    pulse_chk(50, 1'b1, 50, 1'b1, "p50_b");
    pulse_chk(50, 1'b1, 50, 1'b1, "p50_c");
    chk("p50_overruns", ovr_cnt - o0, 2);
    chk("p50_held_valid", 32'(valid), 1);
    chk("p50_held_period", 32'(period), 50);
    ready = 1'b1;
    @(negedge clk);
    chk("p50_accept_valid", 32'(valid), 0);
    chk("p50_accept_period", 32'(period), 50);

    // stall: edges 1200 apart, then 80
    pulse_chk(1001, 1'b1, 51, 1'b0, "stall_first");
    chk("stall_before_timeout", 32'(stall), 0);
    @(negedge clk);
    chk("stall_at_timeout", 32'(stall), 1);
    repeat (198) @(negedge clk);
    chk("stall_held", 32'(stall), 1);
    pulse_chk(80, 1'b0, 0, 1'b0, "stall_edge");
    chk("stall_cleared", 32'(stall), 0);
    pulse_chk(80, 1'b1, 80, 1'b0, "after_stall");

    // reset 40 cycles into a measurement
    pulse_chk(40, 1'b1, 80, 1'b0, "mid_pre");
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("mid_rst_period",  32'(period),  0);
    chk("mid_rst_valid",   32'(valid),   0);
    chk("mid_rst_stall",   32'(stall),   0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_state",   32'(dut.state), 32'(IDLE));
    repeat (59) @(negedge clk);
    pulse_chk(100, 1'b0, 0, 1'b0, "mid_first");
    pulse_chk(100, 1'b1, 100, 1'b0, "mid_second");

    // period 2, ready tracking pulse_in so accept and new result coincide
    o0 = ovr_cnt;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) begin
        chk("p2_first_valid", 32'(valid), 1);
        chk("p2_first_period", 32'(period), 100);
      end
      if (i >= 5) begin
        chk("p2_valid", 32'(valid), 1);
        chk("p2_period", 32'(period), 2);
      end
      pulse_in = (i % 2 == 0);
      ready    = pulse_in;
      @(negedge clk);
    end
    chk("p2_no_overrun", ovr_cnt - o0, 0);
    pulse_in = 1'b0;
    ready    = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
